// File: rtl/fir_coef_loader.sv
`default_nettype none
// ============================================================================
// Module   : fir_coef_loader
// Brief    : Coefficient table load sequencer for the RAM-based FIR filter.
//            Streams FILTER_ORDER coefficients into the filter's write port,
//            blanks the sample strobe while the table is inconsistent and
//            waits for the delay line to refill before flagging coef_ok_o.
// Revision : 1.0 - initial release
// ============================================================================
module fir_coef_loader #(
  parameter int FILTER_ORDER = 256,
  parameter int DATA_WIDTH   = 16,
  parameter int COEF_WIDTH   = 16,
  parameter int COEF_AWIDTH  = $clog2(FILTER_ORDER)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   load_start_i,
  input  logic                   load_abort_i,
  input  logic [COEF_WIDTH-1:0]  coef_i,
  input  logic                   coef_val_i,
  output logic                   coef_rdy_o,
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic                   data_val_i,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic                   data_val_o,
  output logic                   coef_we_o,
  output logic [COEF_AWIDTH-1:0] coef_addr_o,
  output logic [COEF_WIDTH-1:0]  coef_data_o,
  output logic                   busy_o,
  output logic                   coef_ok_o,
  output logic                   done_o,
  output logic [1:0]             err_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // One extra counter bit so a power-of-two order cannot wrap before the end.
  localparam logic [COEF_AWIDTH:0] c_cnt_last = (COEF_AWIDTH+1)'(FILTER_ORDER - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [COEF_AWIDTH:0]   r_cnt;
  logic [COEF_AWIDTH:0]   w_cnt_nxt;
  logic                   w_accept;
  logic                   w_we_nxt;
  logic                   w_done_nxt;
  logic                   w_ok_nxt;
  logic [1:0]             w_err_nxt;

  assign coef_rdy_o = (r_state == ST_LOAD);
  // An aborted beat is still consumed; it simply never reaches the write port.
  assign w_accept   = coef_val_i & coef_rdy_o;

  // State and shared beat/settle counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; abort outranks start and any accepted beat.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_we_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 2'b00;
    w_ok_nxt    = coef_ok_o;
    case (r_state)
      ST_IDLE: begin
        if (load_start_i) begin
          w_state_nxt = ST_LOAD;
          w_cnt_nxt   = '0;
          w_ok_nxt    = 1'b0;
        end
      end
      ST_LOAD: begin
        if (load_abort_i) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 2'b01;
        end else begin
          if (load_start_i) begin
            w_err_nxt = 2'b10;
          end
          if (w_accept) begin
            w_we_nxt  = 1'b1;
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == c_cnt_last) begin
              w_state_nxt = ST_SETTLE;
              w_cnt_nxt   = '0;
            end
          end
        end
      end
      ST_SETTLE: begin
        if (load_abort_i) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 2'b01;
        end else begin
          if (load_start_i) begin
            w_err_nxt = 2'b10;
          end
          if (data_val_i) begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == c_cnt_last) begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
              w_ok_nxt    = 1'b1;
            end
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered outputs: coefficient write port, gated sample path and status.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      coef_we_o   <= 1'b0;
      coef_addr_o <= '0;
      coef_data_o <= '0;
      data_o      <= '0;
      data_val_o  <= 1'b0;
      busy_o      <= 1'b0;
      coef_ok_o   <= 1'b1;
      done_o      <= 1'b0;
      err_o       <= 2'b00;
    end else begin
      coef_we_o <= w_we_nxt;
      if (w_we_nxt) begin
        coef_addr_o <= r_cnt[COEF_AWIDTH-1:0];
        coef_data_o <= coef_i;
      end
      if (data_val_i) begin
        data_o <= data_i;
      end
      data_val_o <= data_val_i & (r_state != ST_LOAD);
      busy_o     <= (w_state_nxt != ST_IDLE);
      coef_ok_o  <= w_ok_nxt;
      done_o     <= w_done_nxt;
      err_o      <= w_err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_coef_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_coef_loader
// Brief    : Directed self-checking bench for fir_coef_loader (order 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_coef_loader;

  localparam int FILTER_ORDER = 8;
  localparam int DATA_WIDTH   = 16;
  localparam int COEF_WIDTH   = 16;
  localparam int COEF_AWIDTH  = 3;

  logic                   clk;
  logic                   rst_n;
  logic                   load_start_i;
  logic                   load_abort_i;
  logic [COEF_WIDTH-1:0]  coef_i;
  logic                   coef_val_i;
  logic                   coef_rdy_o;
  logic [DATA_WIDTH-1:0]  data_i;
  logic                   data_val_i;
  logic [DATA_WIDTH-1:0]  data_o;
  logic                   data_val_o;
  logic                   coef_we_o;
  logic [COEF_AWIDTH-1:0] coef_addr_o;
  logic [COEF_WIDTH-1:0]  coef_data_o;
  logic                   busy_o;
  logic                   coef_ok_o;
  logic                   done_o;
  logic [1:0]             err_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  logic [COEF_AWIDTH-1:0] wr_addr[$];
  logic [COEF_WIDTH-1:0]  wr_data[$];

  fir_coef_loader #(
    .FILTER_ORDER (FILTER_ORDER),
    .DATA_WIDTH   (DATA_WIDTH),
    .COEF_WIDTH   (COEF_WIDTH),
    .COEF_AWIDTH  (COEF_AWIDTH)
  ) u_dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .load_start_i (load_start_i),
    .load_abort_i (load_abort_i),
    .coef_i       (coef_i),
    .coef_val_i   (coef_val_i),
    .coef_rdy_o   (coef_rdy_o),
    .data_i       (data_i),
    .data_val_i   (data_val_i),
    .data_o       (data_o),
    .data_val_o   (data_val_o),
    .coef_we_o    (coef_we_o),
    .coef_addr_o  (coef_addr_o),
    .coef_data_o  (coef_data_o),
    .busy_o       (busy_o),
    .coef_ok_o    (coef_ok_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every coefficient write and done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (coef_we_o) begin
      wr_addr.push_back(coef_addr_o);
      wr_data.push_back(coef_data_o);
    end
    if (done_o) n_done++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  // Full load with back-to-back beats base..base+7 and 8 settle samples.
  task automatic do_load(input logic [15:0] base);
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
    coef_val_i   = 1'b1;
    for (int i = 0; i < FILTER_ORDER; i++) begin
      coef_i = base + 16'(i);
      tick();
    end
    coef_val_i = 1'b0;
    data_val_i = 1'b1;
    for (int i = 0; i < FILTER_ORDER; i++) tick();
    data_val_i = 1'b0;
  endtask

  initial begin
    logic [13:0] pat;
    logic        dv;
    logic        acc;
    int          cnt_dv;
    int          b;
    int          done_before;

    rst_n = 1'b0; load_start_i = 1'b0; load_abort_i = 1'b0;
    coef_i = '0; coef_val_i = 1'b0; data_i = '0; data_val_i = 1'b0;
    tick();
    tick();

    // ---- reset values
    check("rst_rdy",  32'(coef_rdy_o),  32'd0);
    check("rst_we",   32'(coef_we_o),   32'd0);
    check("rst_addr", 32'(coef_addr_o), 32'd0);
    check("rst_data", 32'(coef_data_o), 32'd0);
    check("rst_do",   32'(data_o),      32'd0);
    check("rst_dvo",  32'(data_val_o),  32'd0);
    check("rst_busy", 32'(busy_o),      32'd0);
    check("rst_done", 32'(done_o),      32'd0);
    check("rst_err",  32'(err_o),       32'd0);
    check("rst_ok",   32'(coef_ok_o),   32'd1);
    rst_n = 1'b1;
    tick();

    // ---- nominal load with gating during LOAD
    clear_log();
    load_start_i = 1'b1;
    tick();
    check("nom_busy", 32'(busy_o),     32'd1);
    check("nom_rdy",  32'(coef_rdy_o), 32'd1);
    check("nom_ok0",  32'(coef_ok_o),  32'd0);
    load_start_i = 1'b0;
    coef_val_i   = 1'b1;
    data_val_i   = 1'b1;
    for (int i = 0; i < FILTER_ORDER; i++) begin
      coef_i = 16'(i + 1);
      data_i = 16'h0100 + 16'(i);
      tick();
      check("nom_we",   32'(coef_we_o),   32'd1);
      check("nom_addr", 32'(coef_addr_o), 32'(i));
      check("nom_data", 32'(coef_data_o), 32'(i + 1));
      check("nom_gate", 32'(data_val_o),  32'd0);
      check("nom_do",   32'(data_o),      32'h0100 + 32'(i));
      check("nom_rdy",  32'(coef_rdy_o),  (i < FILTER_ORDER - 1) ? 32'd1 : 32'd0);
    end
    coef_val_i = 1'b0;

    // ---- settle with irregular sample strobe; 8th sample ends the settle
    pat    = 14'b10110111001101;
    cnt_dv = 0;
    for (int k = 0; k < 14; k++) begin
      dv         = pat[k];
      data_val_i = dv;
      data_i     = 16'h0200 + 16'(k);
      tick();
      if (dv) cnt_dv++;
      check("set_dvo", 32'(data_val_o), 32'(dv));
      if (dv) check("set_do", 32'(data_o), 32'h0200 + 32'(k));
      check("set_done", 32'(done_o),    32'(dv && cnt_dv == FILTER_ORDER));
      check("set_ok",   32'(coef_ok_o), 32'(cnt_dv >= FILTER_ORDER));
      check("set_busy", 32'(busy_o),    32'(cnt_dv < FILTER_ORDER));
    end
    data_val_i = 1'b0;
    check("nom_ndone", 32'(n_done), 32'd1);
    check("nom_nwr",   32'(wr_addr.size()), 32'd8);
    for (int i = 0; i < wr_addr.size(); i++) begin
      check("nom_log_a", 32'(wr_addr[i]), 32'(i));
      check("nom_log_d", 32'(wr_data[i]), 32'(i + 1));
    end

    // ---- backpressure gaps: valid 1,0,0,1,0,0,...
    clear_log();
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
    b = 0;
    for (int k = 0; k < 40 && b < FILTER_ORDER; k++) begin
      coef_val_i = (k % 3 == 0);
      coef_i     = 16'h0010 + 16'(b);
      acc        = coef_val_i;
      tick();
      if (acc) b++;
    end
    coef_val_i = 1'b0;
    tick();
    check("bp_nwr",  32'(wr_addr.size()), 32'd8);
    check("bp_rdy",  32'(coef_rdy_o), 32'd0);
    for (int i = 0; i < wr_addr.size(); i++) begin
      check("bp_log_a", 32'(wr_addr[i]), 32'(i));
      check("bp_log_d", 32'(wr_data[i]), 32'h10 + 32'(i));
    end

    // ---- abort during SETTLE, then abort in IDLE is silent
    load_abort_i = 1'b1;
    tick();
    check("abs_err",  32'(err_o),     32'd1);
    check("abs_busy", 32'(busy_o),    32'd0);
    check("abs_ok",   32'(coef_ok_o), 32'd0);
    tick();
    check("abi_err",  32'(err_o),     32'd0);
    load_abort_i = 1'b0;

    // ---- abort coincident with the 5th beat
    clear_log();
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
    coef_val_i   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      coef_i       = 16'h0030 + 16'(i);
      load_abort_i = (i == 4);
      tick();
    end
    load_abort_i = 1'b0;
    coef_val_i   = 1'b0;
    check("ab5_we",   32'(coef_we_o),   32'd0);
    check("ab5_err",  32'(err_o),       32'd1);
    check("ab5_rdy",  32'(coef_rdy_o),  32'd0);
    check("ab5_ok",   32'(coef_ok_o),   32'd0);
    check("ab5_busy", 32'(busy_o),      32'd0);
    check("ab5_addr", 32'(coef_addr_o), 32'd3);
    check("ab5_data", 32'(coef_data_o), 32'h33);
    tick();
    check("ab5_err1", 32'(err_o), 32'd0);
    check("ab5_nwr",  32'(wr_addr.size()), 32'd4);
    clear_log();
    do_load(16'h0040);
    check("rel_ok",   32'(coef_ok_o), 32'd1);
    check("rel_done", 32'(done_o),    32'd1);
    check("rel_nwr",  32'(wr_addr.size()), 32'd8);
    if (wr_data.size() == 8) check("rel_last", 32'(wr_data[7]), 32'h47);
    tick();

    // ---- start request during SETTLE
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
    coef_val_i   = 1'b1;
    for (int i = 0; i < FILTER_ORDER; i++) begin
      coef_i = 16'h0050 + 16'(i);
      tick();
    end
    coef_val_i  = 1'b0;
    done_before = n_done;
    for (int k = 0; k < FILTER_ORDER; k++) begin
      data_val_i   = 1'b1;
      load_start_i = (k == 3);
      tick();
      check("sws_err",  32'(err_o),  (k == 3) ? 32'd2 : 32'd0);
      check("sws_done", 32'(done_o), 32'(k == FILTER_ORDER - 1));
    end
    load_start_i = 1'b0;
    data_val_i   = 1'b0;
    tick();
    check("sws_ndone", 32'(n_done - done_before), 32'd1);
    check("sws_ok",    32'(coef_ok_o), 32'd1);

    // ---- asynchronous reset after the 3rd beat
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
    coef_val_i   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      coef_i = 16'h0060 + 16'(i);
      tick();
    end
    coef_val_i = 1'b0;
    check("mr_pre_we", 32'(coef_we_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_we",   32'(coef_we_o),   32'd0);
    check("mr_addr", 32'(coef_addr_o), 32'd0);
    check("mr_data", 32'(coef_data_o), 32'd0);
    check("mr_rdy",  32'(coef_rdy_o),  32'd0);
    check("mr_busy", 32'(busy_o),      32'd0);
    check("mr_ok",   32'(coef_ok_o),   32'd1);
    check("mr_do",   32'(data_o),      32'd0);
    #2 rst_n = 1'b1;
    tick();
    clear_log();
    do_load(16'h0070);
    check("mr_nwr", 32'(wr_addr.size()), 32'd8);
    if (wr_addr.size() == 8) begin
      check("mr_a0", 32'(wr_addr[0]), 32'd0);
      check("mr_d0", 32'(wr_data[0]), 32'h70);
    end
    check("mr_ok2", 32'(coef_ok_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_coef_loader.md
# fir_coef_loader

Load sequencer for the RAM-based FIR filter's coefficient write bus. It accepts a ready/valid stream of exactly FILTER_ORDER coefficients, writes them to addresses 0..FILTER_ORDER-1 and blanks the filter's input strobe while the table is inconsistent. After the load it tracks the delay-line settle period and reports when filter output is trustworthy again. It sits between the host/config logic and the filter instance, and drives the filter's coef_we_i, coef_addr_i, coef_data_i and data_val_i.

## Interface
- FILTER_ORDER, 256, number of coefficients per load; also the settle length in input samples
- DATA_WIDTH, 16, sample width
- COEF_WIDTH, 16, coefficient width
- COEF_AWIDTH, $clog2(FILTER_ORDER), coefficient address width
- clk_i  in  1  single clock
- rst_n_i  in  1  reset, asynchronous, active-low
- load_start_i  in  1  single-cycle request to start a table load
- load_abort_i  in  1  abort an active load
- coef_i  in  COEF_WIDTH  coefficient stream data
- coef_val_i  in  1  coefficient stream valid
- coef_rdy_o  out  1  coefficient stream ready
- data_i  in  DATA_WIDTH  sample from source
- data_val_i  in  1  sample strobe from source
- data_o  out  DATA_WIDTH  sample to filter
- data_val_o  out  1  gated sample strobe to filter
- coef_we_o  out  1  coefficient write enable to filter
- coef_addr_o  out  COEF_AWIDTH  coefficient address to filter
- coef_data_o  out  COEF_WIDTH  coefficient data to filter
- busy_o  out  1  state is not IDLE
- coef_ok_o  out  1  table complete and delay line settled
- done_o  out  1  one-cycle pulse when a load finishes settling
- err_o  out  2  one-cycle pulses: [0] abort, [1] start while busy

## Operation
- FSM states: IDLE, LOAD, SETTLE.
- coef_rdy_o = (state == LOAD), combinational from state. A beat is accepted when coef_val_i & coef_rdy_o.
- **IDLE**
  - data_val_o follows data_val_i.
  - load_start_i -> LOAD: clears beat counter cnt, sets coef_ok_o = 0.
- **LOAD**
  - Each accepted beat registers coef_we_o = 1, coef_addr_o = cnt, coef_data_o = coef_i, then cnt++.
  - The beat accepted with cnt == FILTER_ORDER-1 -> SETTLE and clears the settle counter.
  - data_val_o is forced 0; incoming samples are dropped.
- **SETTLE**
  - Samples pass through to the filter.
  - The settle counter increments per data_val_i.
  - When it reaches FILTER_ORDER -> IDLE, done_o pulses and coef_ok_o = 1.
  - The done_o/coef_ok_o update is registered on the same edge as the last counted sample.
- **Abort**: load_abort_i in LOAD or SETTLE -> IDLE, err_o[0] pulses, coef_ok_o stays 0 until a later load completes. Abort in IDLE is ignored with no error.
- **Start while busy**: load_start_i in LOAD or SETTLE is ignored and err_o[1] pulses.
- **Priorities within one cycle**
  - load_abort_i beats load_start_i and beats an accepted beat in the same cycle.
  - That beat is not written (coef_we_o stays 0), but the source sees it as consumed.
- coef_addr_o and coef_data_o hold their last values when coef_we_o = 0.
- The counter is COEF_AWIDTH+1 bits wide, so FILTER_ORDER equal to a power of two does not wrap before termination.

## Timing
- **Reset values**: state IDLE, coef_rdy_o 0, coef_we_o 0, coef_addr_o 0, coef_data_o 0, data_o 0, data_val_o 0, busy_o 0, done_o 0, err_o 0, coef_ok_o 1 (power-up table from MIF is valid).
- **Data path**: data_o/data_val_o are registered, latency 1 cycle. data_o updates on every data_val_i, including in LOAD.
- **Coefficient write**: latency 1 cycle from accept to coef_we_o.
- **Minimum load**: start at edge 0 with coef_val_i held high gives coef_rdy_o high cycles 1..FILTER_ORDER. The last write is at cycle FILTER_ORDER+1 and SETTLE is entered at cycle FILTER_ORDER+1.
- busy_o is registered and high from the cycle after load_start_i until the cycle after done_o/abort.
- **Reset mid-load**: asynchronous return to reset values. The partial table is not flagged; the controlling software must reload.

## Test plan
- **Nominal load**: FILTER_ORDER = 8, start, stream 1..8 back to back -> coef_we_o high 8 cycles at addresses 0..7 with data 1..8; coef_rdy_o low after the 8th accept; after 8 data_val_i pulses, done_o pulses once and coef_ok_o = 1.
- **Gating**: data_val_i every cycle during LOAD -> data_val_o = 0 throughout LOAD; in SETTLE data_val_o equals data_val_i delayed 1 cycle, and data_o matches.
- **Backpressure gaps**: coef_val_i toggling 1,0,0,1,... -> writes only on accepted beats, addresses contiguous 0..7 with no skipped or duplicated address.
- **Abort coincident with the 5th beat** -> 4 writes only, err_o = 2'b01 for one cycle, state IDLE, coef_ok_o = 0, coef_rdy_o = 0; a following full load restores coef_ok_o = 1.
- **load_start_i during SETTLE** -> err_o = 2'b10 one cycle, settle count unaffected, done_o still occurs on schedule.
- **rst_n_i low after the 3rd beat** -> all outputs at reset values asynchronously (before the next edge), coef_ok_o = 1; after release, a new load starts at address 0.
